// File: rtl/alu_cmd_sequencer_if.sv
// Bus bundle for alu_cmd_sequencer: command stream in, ALU issue/return
// signals, and the held result stream out. The slave modport is the
// sequencer's view; the master modport is the surrounding environment
// (command producer, ALU, result consumer).
interface alu_cmd_sequencer_if #(
  parameter int A_WIDTH       = 16,
  parameter int B_WIDTH       = 16,
  parameter int ALU_FUN_WIDTH = 4,
  parameter int RES_WIDTH     = 32,
  parameter int FIFO_DEPTH    = 4
);
  localparam int LVL_WIDTH = $clog2(FIFO_DEPTH) + 1;

  // Command stream
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [A_WIDTH-1:0]       cmd_a;
  logic [B_WIDTH-1:0]       cmd_b;
  logic [ALU_FUN_WIDTH-1:0] cmd_fun;
  logic [LVL_WIDTH-1:0]     cmd_level;

  // Issue side towards the ALU
  logic [A_WIDTH-1:0]       alu_a;
  logic [B_WIDTH-1:0]       alu_b;
  logic [ALU_FUN_WIDTH-1:0] alu_fun;

  // Return side from the ALU
  logic [RES_WIDTH-1:0]     arith_out;
  logic                     carry_out;
  logic                     arith_flag;
  logic [15:0]              logic_out;
  logic                     logic_flag;
  logic [1:0]               cmp_out;
  logic                     cmp_flag;
  logic [15:0]              shift_out;
  logic                     shift_flag;

  // Result stream
  logic                     res_valid;
  logic                     res_ready;
  logic [RES_WIDTH-1:0]     res_data;
  logic                     res_carry;
  logic [1:0]               res_unit;
  logic                     res_err;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_fun,
    output cmd_ready, cmd_level,
    output alu_a, alu_b, alu_fun,
    input  arith_out, carry_out, arith_flag, logic_out, logic_flag,
    input  cmp_out, cmp_flag, shift_out, shift_flag,
    output res_valid, res_data, res_carry, res_unit, res_err,
    input  res_ready
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_fun,
    input  cmd_ready, cmd_level,
    input  alu_a, alu_b, alu_fun,
    output arith_out, carry_out, arith_flag, logic_out, logic_flag,
    output cmp_out, cmp_flag, shift_out, shift_flag,
    input  res_valid, res_data, res_carry, res_unit, res_err,
    output res_ready
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the ALU: buffers {A,B,FUN} commands in a small FIFO,
// issues one at a time, waits out the ALU's one-cycle registered latency,
// captures the selected unit's output/flag and holds it under valid/ready.
module alu_cmd_sequencer #(
  parameter int A_WIDTH       = 16,
  parameter int B_WIDTH       = 16,
  parameter int ALU_FUN_WIDTH = 4,
  parameter int RES_WIDTH     = 32,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst,
  alu_cmd_sequencer_if.slave bus
);
  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int LVL_WIDTH = PTR_WIDTH + 1;

  typedef struct packed {
    logic [A_WIDTH-1:0]       a;
    logic [B_WIDTH-1:0]       b;
    logic [ALU_FUN_WIDTH-1:0] fun;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  // FIFO storage and bookkeeping
  cmd_t                 mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [LVL_WIDTH-1:0] count;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  cmd_t                 head;

  // FSM and registered outputs
  state_t                   state;
  logic [A_WIDTH-1:0]       alu_a_q;
  logic [B_WIDTH-1:0]       alu_b_q;
  logic [ALU_FUN_WIDTH-1:0] alu_fun_q;
  logic                     res_valid_q;
  logic [RES_WIDTH-1:0]     res_data_q;
  logic                     res_carry_q;
  logic [1:0]               res_unit_q;
  logic                     res_err_q;

  // Selected-unit view of the ALU return bus
  logic [1:0]           unit;
  logic [RES_WIDTH-1:0] sel_data;
  logic                 sel_flag;
  logic                 sel_carry;

  assign full  = (count == LVL_WIDTH'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = bus.cmd_valid && !full;
  assign head  = mem[rd_ptr];
  assign unit  = alu_fun_q[ALU_FUN_WIDTH-1 -: 2];

  // The FSM pops when idle with work waiting, or when the held result is
  // taken and another command is queued (back-to-back issue).
  assign pop = !empty && ((state == S_IDLE) || (state == S_HOLD && bus.res_ready));

  assign bus.cmd_ready = !full;
  assign bus.cmd_level = count;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_fun   = alu_fun_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_carry = res_carry_q;
  assign bus.res_unit  = res_unit_q;
  assign bus.res_err   = res_err_q;

  // Command storage write
  // NOTE: the storage array has no reset; count/pointers alone say which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: bus.cmd_a, b: bus.cmd_b, fun: bus.cmd_fun};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
  // NOTE: sequential state always uses <= so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      if (push && !pop)      count <= count + LVL_WIDTH'(1);
      else if (pop && !push) count <= count - LVL_WIDTH'(1);
    end
  end

  // Result mux by unit select; carry is meaningful only for the arith unit
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    sel_data  = bus.arith_out;
    sel_flag  = bus.arith_flag;
    sel_carry = bus.carry_out;
    case (unit)
      2'b00: begin
        sel_data  = bus.arith_out;
        sel_flag  = bus.arith_flag;
        sel_carry = bus.carry_out;
      end
      2'b01: begin
        sel_data  = {{(RES_WIDTH-16){1'b0}}, bus.logic_out};
        sel_flag  = bus.logic_flag;
        sel_carry = 1'b0;
      end
      2'b10: begin
        sel_data  = {{(RES_WIDTH-2){1'b0}}, bus.cmp_out};
        sel_flag  = bus.cmp_flag;
        sel_carry = 1'b0;
      end
      2'b11: begin
        sel_data  = {{(RES_WIDTH-16){1'b0}}, bus.shift_out};
        sel_flag  = bus.shift_flag;
        sel_carry = 1'b0;
      end
    endcase
  end

  // Sequencer FSM: IDLE -> ISSUE -> WAIT -> HOLD, with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_unit_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            alu_a_q   <= head.a;
            alu_b_q   <= head.b;
            alu_fun_q <= head.fun;
            state     <= S_ISSUE;
          end
        end
        // ALU registers its outputs from alu_* at this edge
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          res_valid_q <= 1'b1;
          res_data_q  <= sel_data;
          res_carry_q <= sel_carry;
          res_unit_q  <= unit;
          res_err_q   <= !sel_flag;
          state       <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            if (pop) begin
              alu_a_q   <= head.a;
              alu_b_q   <= head.b;
              alu_fun_q <= head.fun;
              state     <= S_ISSUE;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
